// File: rtl/cnn_pkg.sv
// Shared CNN definitions: feature width, feature type, layer-2 map size and
// the receive-side state encoding.
package cnn_pkg;

    localparam int DW       = 18;
    localparam int L2_N_WIN = 25;

    typedef logic [DW-1:0] fmap_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } rxstate_t;

endpackage

// File: rtl/pool4.sv
// 4-to-1 pooling of one channel's 2x2 window. Max pooling by default; average
// pooling (sum of four, shift right by 2) when L2_POOL_RX_AVG_EN is defined.
module pool4
    import cnn_pkg::*;
#(
    parameter int W = DW
) (
    input  logic [W-1:0] win_i [3:0],
    output logic [W-1:0] pool_o
);

`ifdef L2_POOL_RX_AVG_EN
    logic [W+1:0] sum;

    assign sum    = {2'b00, win_i[0]} + {2'b00, win_i[1]}
                  + {2'b00, win_i[2]} + {2'b00, win_i[3]};
    assign pool_o = W'(sum >> 2);
`else
    logic [W-1:0] max01;
    logic [W-1:0] max23;

    // Inputs are post-ReLU, so an unsigned compare is the correct max.
    assign max01  = (win_i[0] > win_i[1]) ? win_i[0] : win_i[1];
    assign max23  = (win_i[2] > win_i[3]) ? win_i[2] : win_i[3];
    assign pool_o = (max01 > max23) ? max01 : max23;
`endif

endmodule

// File: rtl/l2_pool_rx.sv
// Layer-2 read-port receiver: pools each window per channel, buffers N_WIN
// results, streams them out and pulses tx_done. Mode: L2_POOL_RX_AVG_EN.
module l2_pool_rx
    import cnn_pkg::*;
#(
    parameter int N_WIN  = L2_N_WIN,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic [DW-1:0] din_0 [3:0],
    input  logic [DW-1:0] din_1 [3:0],
    input  logic [DW-1:0] din_2 [3:0],
    input  logic [DW-1:0] din_3 [3:0],
    output logic          tx_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data [3:0],
    output logic [4:0]    out_idx,
    output logic          out_last,
    output logic          ovf
);

    localparam int              PW   = $clog2(N_WIN + 1);
    localparam logic [PW-1:0]   FULL = PW'(N_WIN);
    localparam logic [PW-1:0]   LAST = PW'(N_WIN - 1);

    rxstate_t          state_q, state_d;
    logic [RD_LAT-1:0] cap_q, cap_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     rd_idx;
    logic              ovf_q, ovf_d;
    logic              cap, wr_en, hs;

    logic [DW-1:0]     mem_q  [N_WIN][3:0];
    logic [DW-1:0]     win    [3:0][3:0];
    logic [DW-1:0]     pooled [3:0];

    assign win[0] = din_0;
    assign win[1] = din_1;
    assign win[2] = din_2;
    assign win[3] = din_3;

    for (genvar c = 0; c < 4; c++) begin : g_pool
        pool4 #(.W(DW)) u_pool4 (
            .win_i  (win[c]),
            .pool_o (pooled[c])
        );
    end

    // The rd strobe, delayed to line up with the RAM read data.
    assign cap = cap_q[RD_LAT-1];
    assign ovf = ovf_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        cap_d     = RD_LAT'({cap_q, rd});
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        wr_en     = 1'b0;
        tx_done   = 1'b0;

        rd_idx    = (rd_ptr_q < FULL) ? rd_ptr_q : LAST;
        out_data  = mem_q[rd_idx];
        out_idx   = 5'(rd_idx);
        out_valid = (state_q == RUN) && (rd_ptr_q < wr_ptr_q);
        out_last  = out_valid && (rd_ptr_q == LAST);
        hs        = out_valid && out_ready;

        case (state_q)
            RUN: begin
                if (cap) begin
                    if (wr_ptr_q < FULL) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (hs) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (out_last) state_d = DONE;
                end
            end
            DONE: begin
                // Re-arm for the next image; anything captured now is lost.
                tx_done  = 1'b1;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cap_d    = '0;
                if (cap) ovf_d = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q  <= RUN;
            cap_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the result buffer is register-based and reset as well, so that
    // out_data reads 0 out of reset instead of X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WIN; i++) begin
                for (int c = 0; c < 4; c++) begin
                    mem_q[i][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= pooled;
        end
    end

endmodule

// File: tb/tb_l2_pool_rx.sv
// Self-checking bench for l2_pool_rx: table vectors, directed map sequences
// and a randomized run against a cycle-level reference model.
`timescale 1ns/1ps
module tb_l2_pool_rx;
    import cnn_pkg::*;

    localparam int NW = L2_N_WIN;
    localparam int NV = 7;

    typedef logic [3:0][3:0][DW-1:0] win_t;   // [channel][word]
    typedef struct {
        logic [DW-1:0] w [4];
        logic [DW-1:0] exp_max;
        logic [DW-1:0] exp_avg;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, rd, out_ready;
    logic          tx_done, out_valid, out_last, ovf;
    logic [DW-1:0] din_0 [3:0];
    logic [DW-1:0] din_1 [3:0];
    logic [DW-1:0] din_2 [3:0];
    logic [DW-1:0] din_3 [3:0];
    logic [DW-1:0] out_data [3:0];
    logic [4:0]    out_idx;

    always #5 clk = ~clk;

    l2_pool_rx #(.N_WIN(NW), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .din_0     (din_0),
        .din_1     (din_1),
        .din_2     (din_2),
        .din_3     (din_3),
        .tx_done   (tx_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_txd = 0;
    int n_hs  = 0;

    // Reference model state: stored pooled results, counts, flags.
    logic [3:0][DW-1:0] m_buf [NW];
    int                 m_wr, m_rd;
    bit                 m_done, m_cap, m_ovf;
    win_t               m_pend;

    vec_t tbl [NV];

    function automatic logic [DW-1:0] pool_ref(input logic [3:0][DW-1:0] w);
`ifdef L2_POOL_RX_AVG_EN
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(w[k]);
        return DW'(s / 4);
`else
        logic [DW-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (w[k] > m) m = w[k];
        return m;
`endif
    endfunction

    function automatic logic [DW-1:0] tbl_exp(input int v);
`ifdef L2_POOL_RX_AVG_EN
        return tbl[v].exp_avg;
`else
        return tbl[v].exp_max;
`endif
    endfunction

    // Window k = {k,k+1,k+2,k+3}: max is k+3, average is (4k+6)/4 = k+1.
    function automatic logic [31:0] ramp_exp(input int k);
`ifdef L2_POOL_RX_AVG_EN
        return 32'(k + 1);
`else
        return 32'(k + 3);
`endif
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                w[c][k] = ($urandom_range(0, 7) == 0) ? '1 : DW'($urandom);
        return w;
    endfunction

    task automatic set_vec(input int i, input int a, input int b, input int c,
                           input int d, input int em, input int ea);
        tbl[i].w[0] = DW'(a); tbl[i].w[1] = DW'(b);
        tbl[i].w[2] = DW'(c); tbl[i].w[3] = DW'(d);
        tbl[i].exp_max = DW'(em);
        tbl[i].exp_avg = DW'(ea);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_din(input win_t w);
        for (int k = 0; k < 4; k++) begin
            din_0[k] = w[0][k];
            din_1[k] = w[1][k];
            din_2[k] = w[2][k];
            din_3[k] = w[3][k];
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = !m_done && (m_rd < m_wr);
        check("out_valid", 32'(out_valid), 32'(ev));
        check("tx_done",   32'(tx_done),   32'(m_done));
        check("ovf",       32'(ovf),       32'(m_ovf));
        check("out_last",  32'(out_last),  32'(ev && (m_rd == NW - 1)));
        if (ev) begin
            check("out_idx", 32'(out_idx), 32'(m_rd));
            for (int c = 0; c < 4; c++)
                check($sformatf("out_data%0d", c), 32'(out_data[c]), 32'(m_buf[m_rd][c]));
        end
        if (tx_done) n_txd++;
    endtask

    // One clock cycle: check current outputs, apply inputs, advance the model.
    // din carries the window of the previous cycle's rd (RAM latency 1).
    task automatic cycle(input bit rd_v, input win_t w, input bit rdy);
        bit ev, hs;
        @(negedge clk);
        cyc++;
        check_outputs();
        ev = !m_done && (m_rd < m_wr);
        hs = ev && rdy;
        rd = rd_v;
        out_ready = rdy;
        drive_din(m_pend);
        if (out_valid && rdy) n_hs++;
        if (m_done) begin
            if (m_cap) m_ovf = 1'b1;
            m_wr = 0; m_rd = 0; m_done = 1'b0; m_cap = 1'b0;
        end else begin
            if (m_cap) begin
                if (m_wr < NW) begin
                    for (int c = 0; c < 4; c++) m_buf[m_wr][c] = pool_ref(m_pend[c]);
                    m_wr++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (hs) begin
                if (m_rd == NW - 1) m_done = 1'b1;
                m_rd++;
            end
            m_cap = rd_v;
        end
        m_pend = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rd = 1'b0; out_ready = 1'b0;
        drive_din('0);
        m_wr = 0; m_rd = 0; m_done = 1'b0; m_cap = 1'b0; m_ovf = 1'b0; m_pend = '0;
        for (int i = 0; i < NW; i++) m_buf[i] = '0;
        #1;
        check("rst_tx_done",   32'(tx_done),   32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        for (int c = 0; c < 4; c++) check("rst_out_data", 32'(out_data[c]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        win_t          w;
        bit            seen, prev_valid, stall_prev;
        logic [4:0]    prev_idx, snap_idx;
        logic [DW-1:0] snap [3:0];
        logic [DW-1:0] ovf_q [$];
        int            base_txd, t_lastrd, t_done;

        rst_n = 1'b0; rd = 1'b0; out_ready = 1'b0;
        drive_din('0);

        set_vec(0, 5, 9, 3, 7, 9, 6);
        set_vec(1, 4, 8, 12, 17, 17, 10);
        set_vec(2, 0, 0, 0, 0, 0, 0);
        set_vec(3, 'h3FFFF, 'h3FFFF, 'h3FFFF, 'h3FFFF, 'h3FFFF, 'h3FFFF);
        set_vec(4, 'h3FFFF, 0, 0, 0, 'h3FFFF, 'h0FFFF);
        set_vec(5, 1, 1, 1, 2, 2, 1);
        set_vec(6, 7, 6, 5, 100, 100, 29);

        // Table vectors, one window each; words rotated per channel.
        do_reset();
        for (int v = 0; v < NV; v++) begin
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) w[c][k] = tbl[v].w[(k + c) % 4];
            seen = 1'b0;
            for (int j = 0; j < 6 && !seen; j++) begin
                cycle(j == 0, w, 1'b1);
                if (out_valid) begin
                    seen = 1'b1;
                    if (v == 0) check("first_valid_cycle", 32'(j), 32'd2);
                    check("tbl_idx", 32'(out_idx), 32'(v));
                    for (int c = 0; c < 4; c++)
                        check($sformatf("tbl%0d_ch%0d", v, c), 32'(out_data[c]), 32'(tbl_exp(v)));
                end
            end
            if (!seen) check("tbl_timeout", 32'd0, 32'd1);
        end

        // Full ramp map streamed with out_ready high.
        do_reset();
        base_txd = n_txd; prev_valid = 1'b0; prev_idx = '0; t_lastrd = 0; t_done = 0;
        for (int t = 0; t < 32; t++) begin
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) w[c][k] = DW'(t + k);
            cycle(t < NW, w, 1'b1);
            if (t == NW - 1) t_lastrd = cyc;
            if (out_valid) begin
                if (prev_valid) check("stride", 32'(out_idx), 32'(prev_idx) + 32'd1);
                if (out_last) check("last_idx", 32'(out_idx), 32'(NW - 1));
                check("ramp_data", 32'(out_data[2]), ramp_exp(int'(out_idx)));
            end
            if (tx_done) t_done = cyc;
            prev_valid = out_valid;
            prev_idx = out_idx;
        end
        check("map_txdone_count", 32'(n_txd - base_txd), 32'd1);
        check("txdone_latency", 32'(t_done - t_lastrd), 32'd3);

        // Backpressure: out_ready low for 10 cycles mid-map.
        base_txd = n_txd; n_hs = 0; stall_prev = 1'b0; snap_idx = '0;
        for (int c = 0; c < 4; c++) snap[c] = '0;
        for (int t = 0; t < 65; t++) begin
            cycle(t < NW, rand_win(), !(t >= 8 && t < 18));
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_idx", 32'(out_idx), 32'(snap_idx));
                for (int c = 0; c < 4; c++) check("hold_data", 32'(out_data[c]), 32'(snap[c]));
            end
            stall_prev = out_valid && !out_ready;
            snap = out_data;
            snap_idx = out_idx;
        end
        check("bp_delivered", 32'(n_hs), 32'(NW));
        check("bp_txdone", 32'(n_txd - base_txd), 32'd1);

        // Overflow: 26 windows while downstream is stalled.
        ovf_q.delete();
        for (int t = 0; t < 28; t++) begin
            w = rand_win();
            if (t < NW) ovf_q.push_back(pool_ref(w[0]));
            cycle(t < NW + 1, w, 1'b0);
        end
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_valid", 32'(out_valid), 32'd1);
        check("ovf_idx", 32'(out_idx), 32'd0);
        n_hs = 0;
        for (int t = 0; t < 30; t++) begin
            cycle(1'b0, rand_win(), 1'b1);
            if (out_valid) begin
                if (ovf_q.size() > 0) check("ovf_content", 32'(out_data[0]), 32'(ovf_q.pop_front()));
                else check("ovf_extra_result", 32'd1, 32'd0);
            end
        end
        check("ovf_drained", 32'(n_hs), 32'(NW));

        // Reset in the middle of a map: no tx_done, restart at index 0.
        do_reset();
        base_txd = n_txd;
        for (int t = 0; t < 13; t++) cycle(1'b1, rand_win(), 1'b1);
        do_reset();
        check("midreset_no_txdone", 32'(n_txd - base_txd), 32'd0);
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            cycle(t < 3, rand_win(), 1'b1);
            if (out_valid && !seen) begin
                check("restart_idx", 32'(out_idx), 32'd0);
                seen = 1'b1;
            end
        end
        if (!seen) check("restart_timeout", 32'd0, 32'd1);

        // Randomized traffic, including strobes during DONE and overflow.
        do_reset();
        for (int t = 0; t < 900; t++)
            cycle($urandom_range(0, 3) != 0, rand_win(), $urandom_range(0, 2) != 0);
        for (int t = 0; t < 40; t++) cycle(1'b0, rand_win(), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
